pmem_loader: RTL and testbench
==============================

Name: pmem_loader

Overview:
- Boot-time program loader and write-side initiator for program memory.
- Consumes a framed byte stream, typically from the UART receiver, assembles 18-bit instruction words, and drives pmem's address, data and write-enable pins.
- Verifies a frame checksum and reports completion or error.
- Holds the CPU off program memory while a frame is in progress.

Parameters:
- ADDR_WIDTH, default 16: width of pm_addr and of the address fields (matches `ADDR_WIDTH).
- PMEM_WORDS, default 16384: number of pmem words; the valid word range is 0..PMEM_WORDS-1.
- TIMEOUT_CYCLES, default 1000000: maximum idle gap allowed between bytes inside a frame.

Ports:
- rst  input  1  asynchronous reset, active-high
- clk  input  1  clock
- rx_data  input  8  byte from the stream source
- rx_valid  input  1  rx_data is valid
- rx_ready  output  1  loader accepts the byte; transfer happens on clk edge when rx_valid&rx_ready
- pm_addr  output  ADDR_WIDTH  pmem word address
- pm_data  output  18  pmem write data
- pm_wenh  output  1  write enable for pmem bits 17:16
- pm_wenl  output  1  write enable for pmem bits 15:0
- busy  output  1  frame in progress; used as CPU hold
- done  output  1  one-cycle pulse on a good frame
- err_code  output  2  0 none, 1 checksum, 2 timeout, 3 range; sticky until the next magic byte
- word_count  output  16  words written in the current/last frame

Behaviour:
- Reset (asynchronous) clears all state and outputs:
  - state=IDLE, rx_ready=1, pm_*=0, busy=0, done=0, err_code=0, word_count=0, sum=0, timer=0.
- Frame format, in byte order:
  - 0xA5 magic, ADDR_H, ADDR_L, CNT_H, CNT_L.
  - CNT words of 3 bytes each: B0[1:0]=bits 17:16 (B0[7:2] ignored but summed), B1=bits 15:8, B2=bits 7:0.
  - CHK byte.
- Checksum: 8-bit sum of every byte after the magic, including CHK, must equal 0x00 mod 256.
- States: IDLE, HDR (4 bytes), W0, W1, W2, WRITE, CHK.
- IDLE:
  - 0xA5 accepted → HDR; clear err_code, sum and word_count.
  - Any other byte is accepted and discarded.
- HDR:
  - After CNT_L is accepted: if ADDR+CNT > PMEM_WORDS (17-bit compare), set err_code=3 and go to IDLE.
  - Otherwise, if CNT==0 go to CHK; else go to W0.
- W0→W1→W2: each accepted byte is latched into the pm_data slice.
- After B2 is accepted → WRITE for exactly one cycle:
  - rx_ready=0; pm_wenh=pm_wenl=1 with pm_addr and pm_data stable.
  - On the next edge: pm_addr+=1 and word_count+=1.
  - Remaining words → W0; otherwise → CHK.
- pm_wen* are asserted only in WRITE; no partial writes are issued.
- CHK, on accept:
  - sum==0: done=1 for one cycle, err_code stays 0.
  - Otherwise err_code=1.
  - Either way → IDLE.
  - Words already written are not rolled back.
- rx_ready is 1 in every state except WRITE. A byte offered during WRITE waits; it is not lost.
- busy=1 in every state except IDLE.
- Timer:
  - Counts cycles without an accepted byte while state∉{IDLE, WRITE}; reset on every accepted byte.
  - Reaching TIMEOUT_CYCLES sets err_code=2 and forces IDLE.
- Reset mid-frame aborts immediately. Any pm_wen* pulse in flight is dropped; pmem contents already written are kept.
- pm_addr is an ADDR_WIDTH-bit register. The range check guarantees it never exceeds PMEM_WORDS-1 during a write.
- done and err are exclusive. done never coincides with a nonzero err_code update.

Test Plan:
- Good frame A5 00 10 00 01 01 23 45 86 → one write: pm_addr=0x0010, pm_data=18'h12345, wenh=wenl=1 for 1 cycle; then done pulse, err_code=0, word_count=1, busy falls.
- Same frame with CHK=0x87 → write still occurs, err_code=1, no done pulse.
- Header A5 3F FF 00 02 (0x3FFF+2 > 16384) → no write, err_code=3, IDLE; a following garbage byte 0x00 is discarded.
- Frame stalled after B1 with TIMEOUT_CYCLES=16 → err_code=2 after 16 idle cycles, busy=0; next 0xA5 clears err_code.
- rx_valid held high continuously over a 3-word frame → rx_ready low exactly in each WRITE cycle; addresses N, N+1, N+2 written in order with no lost bytes.
- Assert rst during W1 → all outputs at reset values the same cycle; after rst release, a new good frame loads correctly.

Source files
------------

// File: rtl/pmem_loader.sv
// pmem_loader: boot-time program loader. Parses a framed byte stream
// (A5, ADDR_H, ADDR_L, CNT_H, CNT_L, CNT x {B0,B1,B2}, CHK), writes
// 18-bit words into program memory, verifies the frame checksum and
// holds the CPU off pmem while a frame is in progress.
module pmem_loader #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned PMEM_WORDS     = 16384,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                  rst,
  input  logic                  clk,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [ADDR_WIDTH-1:0] pm_addr,
  output logic [17:0]           pm_data,
  output logic                  pm_wenh,
  output logic                  pm_wenl,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            err_code,
  output logic [15:0]           word_count
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [7:0]  MAGIC = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_W0, S_W1, S_W2, S_WRITE, S_CHK
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [1:0]      r_hcnt;
  logic [23:0]     r_hdr;
  logic [15:0]     r_cnt;
  logic [7:0]      r_sum;
  logic [TW-1:0]   r_timer;

  logic            w_accept;
  logic            w_timeout;
  logic            w_last;
  logic            w_range_bad;
  logic [15:0]     w_hdr_addr;
  logic [15:0]     w_cnt;
  logic [16:0]     w_end;
  logic [7:0]      w_sum_next;

  // Handshake and status outputs depend on state only
  assign rx_ready = (r_state != S_WRITE);
  assign busy     = (r_state != S_IDLE);
  assign pm_wenh  = (r_state == S_WRITE);
  assign pm_wenl  = (r_state == S_WRITE);

  assign w_accept    = rx_valid & rx_ready;
  assign w_hdr_addr  = r_hdr[23:8];
  assign w_cnt       = {r_hdr[7:0], rx_data};
  assign w_end       = {1'b0, w_hdr_addr} + {1'b0, w_cnt};
  assign w_range_bad = (w_end > 17'(PMEM_WORDS));
  assign w_last      = ((word_count + 16'd1) == r_cnt);
  assign w_sum_next  = r_sum + rx_data;
  assign w_timeout   = (r_state != S_IDLE) && (r_state != S_WRITE) && !w_accept &&
                       (r_timer == TW'(TIMEOUT_CYCLES - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && rx_data == MAGIC) w_next = S_HDR;
      S_HDR: begin
        if (w_accept && r_hcnt == 2'd3) begin
          if (w_range_bad)       w_next = S_IDLE;
          else if (w_cnt == '0)  w_next = S_CHK;
          else                   w_next = S_W0;
        end
      end
      S_W0:    if (w_accept) w_next = S_W1;
      S_W1:    if (w_accept) w_next = S_W2;
      S_W2:    if (w_accept) w_next = S_WRITE;
      S_WRITE: w_next = w_last ? S_CHK : S_W0;
      S_CHK:   if (w_accept) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_timeout) w_next = S_IDLE;
  end

  // Datapath: header capture, word assembly, checksum, timer, status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hcnt     <= '0;
      r_hdr      <= '0;
      r_cnt      <= '0;
      r_sum      <= '0;
      r_timer    <= '0;
      pm_addr    <= '0;
      pm_data    <= '0;
      done       <= 1'b0;
      err_code   <= '0;
      word_count <= '0;
    end else begin
      done <= 1'b0;

      if (r_state == S_IDLE || r_state == S_WRITE || w_accept || w_timeout)
        r_timer <= '0;
      else
        r_timer <= r_timer + TW'(1);

      if (w_timeout) err_code <= 2'd2;

      case (r_state)
        S_IDLE: begin
          if (w_accept && rx_data == MAGIC) begin
            err_code   <= '0;
            r_sum      <= '0;
            word_count <= '0;
            r_hcnt     <= '0;
          end
        end
        S_HDR: begin
          if (w_accept) begin
            r_sum  <= w_sum_next;
            r_hcnt <= r_hcnt + 2'd1;
            r_hdr  <= {r_hdr[15:0], rx_data};
            if (r_hcnt == 2'd3) begin
              r_cnt <= w_cnt;
              if (w_range_bad) err_code <= 2'd3;
              else             pm_addr  <= ADDR_WIDTH'(w_hdr_addr);
            end
          end
        end
        S_W0: begin
          if (w_accept) begin
            r_sum          <= w_sum_next;
            pm_data[17:16] <= rx_data[1:0];
          end
        end
        S_W1: begin
          if (w_accept) begin
            r_sum         <= w_sum_next;
            pm_data[15:8] <= rx_data;
          end
        end
        S_W2: begin
          if (w_accept) begin
            r_sum        <= w_sum_next;
            pm_data[7:0] <= rx_data;
          end
        end
        S_WRITE: begin
          pm_addr    <= pm_addr + ADDR_WIDTH'(1);
          word_count <= word_count + 16'd1;
        end
        S_CHK: begin
          if (w_accept) begin
            r_sum <= w_sum_next;
            if (w_sum_next == '0) done     <= 1'b1;
            else                  err_code <= 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_loader.sv
// tb_pmem_loader: directed frames driven into pmem_loader; expected
// pmem writes are queued as each word is sent and matched against the
// write strobes seen on the pmem side.
module tb_pmem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] pm_addr;
  logic [17:0] pm_data;
  logic        pm_wenh;
  logic        pm_wenl;
  logic        busy;
  logic        done;
  logic [1:0]  err_code;
  logic [15:0] word_count;

  pmem_loader #(
    .ADDR_WIDTH(16),
    .PMEM_WORDS(16384),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .rst(rst), .clk(clk), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .pm_addr(pm_addr), .pm_data(pm_data),
    .pm_wenh(pm_wenh), .pm_wenl(pm_wenl), .busy(busy), .done(done),
    .err_code(err_code), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail = 0;
  int          n_writes = 0;
  int          n_done = 0;
  int          n_ready_low = 0;
  logic        prev_wen = 1'b0;
  logic [33:0] exp_q[$];

  task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // pmem-side monitor: every write must match the next queued word
  always @(negedge clk) begin
    if (!rst) begin
      check("wen_pair", 34'(pm_wenh), 34'(pm_wenl));
      check("ready_vs_wen", 34'(rx_ready), 34'(!pm_wenl));
      if (!rx_ready) n_ready_low++;
      if (done) n_done++;
      if (pm_wenl) begin
        logic [33:0] e;
        n_writes++;
        check("wen_single_cycle", 34'(prev_wen), 34'd0);
        check("write_expected", 34'(exp_q.size() != 0), 34'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("write_addr_data", {pm_addr, pm_data}, e);
        end
      end
      prev_wen = pm_wenl;
    end else begin
      prev_wen = 1'b0;
    end
  end

  // Offer a byte and return at the negedge following its acceptance
  task automatic send(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("accept_bound", 34'(n), 34'd0);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [15:0] a, input logic [7:0] b0,
                           input logic [7:0] b1, input logic [7:0] b2);
    exp_q.push_back({a, b0[1:0], b1, b2});
    send(b0);
    send(b1);
    send(b2);
  endtask

  task automatic send_hdr(input logic [7:0] ah, input logic [7:0] al,
                          input logic [7:0] ch, input logic [7:0] cl);
    send(8'hA5);
    send(ah);
    send(al);
    send(ch);
    send(cl);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready", 34'(rx_ready), 34'd1);
    check("rst_busy", 34'(busy), 34'd0);
    check("rst_done", 34'(done), 34'd0);
    check("rst_err", 34'(err_code), 34'd0);
    check("rst_wc", 34'(word_count), 34'd0);
    check("rst_pm", {pm_addr, pm_data}, 34'd0);
    check("rst_wen", 34'({pm_wenh, pm_wenl}), 34'd0);
    rst = 1'b0;
    @(negedge clk);

    // Good single-word frame
    send(8'hA5);
    check("f1_busy", 34'(busy), 34'd1);
    send(8'h00); send(8'h10); send(8'h00); send(8'h01);
    send_word(16'h0010, 8'h01, 8'h23, 8'h45);
    send(8'h86);
    rx_valid = 1'b0;
    check("f1_done", 34'(done), 34'd1);
    check("f1_err", 34'(err_code), 34'd0);
    check("f1_wc", 34'(word_count), 34'd1);
    check("f1_busy_fall", 34'(busy), 34'd0);
    check("f1_addr_post", 34'(pm_addr), 34'h11);
    @(negedge clk);
    check("f1_done_pulse", 34'(done), 34'd0);

    // Same frame, bad checksum
    send_hdr(8'h00, 8'h10, 8'h00, 8'h01);
    send_word(16'h0010, 8'h01, 8'h23, 8'h45);
    send(8'h87);
    rx_valid = 1'b0;
    check("f2_done", 34'(done), 34'd0);
    check("f2_err", 34'(err_code), 34'd1);
    check("f2_wc", 34'(word_count), 34'd1);

    // Range error, then a discarded garbage byte
    send_hdr(8'h3F, 8'hFF, 8'h00, 8'h02);
    rx_valid = 1'b0;
    check("rng_err", 34'(err_code), 34'd3);
    check("rng_busy", 34'(busy), 34'd0);
    check("rng_wc", 34'(word_count), 34'd0);
    send(8'h00);
    rx_valid = 1'b0;
    check("rng_garbage_err", 34'(err_code), 34'd3);
    check("rng_garbage_busy", 34'(busy), 34'd0);

    // Exactly fills the top of pmem: accepted
    send(8'hA5);
    check("edge_err_clr", 34'(err_code), 34'd0);
    send(8'h3F); send(8'hFF); send(8'h00); send(8'h01);
    send_word(16'h3FFF, 8'h00, 8'h00, 8'h07);
    send(8'hBA);
    rx_valid = 1'b0;
    check("edge_done", 34'(done), 34'd1);
    check("edge_err", 34'(err_code), 34'd0);

    // Stall after B1: timeout after 16 idle cycles
    send_hdr(8'h00, 8'h20, 8'h00, 8'h01);
    send(8'h01);
    send(8'h02);
    rx_valid = 1'b0;
    repeat (15) @(negedge clk);
    check("to_busy_before", 34'(busy), 34'd1);
    check("to_err_before", 34'(err_code), 34'd0);
    @(negedge clk);
    check("to_busy", 34'(busy), 34'd0);
    check("to_err", 34'(err_code), 34'd2);

    // Magic clears the error; 3-word frame with rx_valid held high
    send(8'hA5);
    check("to_err_clr", 34'(err_code), 34'd0);
    send(8'h01); send(8'h00); send(8'h00); send(8'h03);
    send_word(16'h0100, 8'h02, 8'hAB, 8'hCD);
    send_word(16'h0101, 8'hFD, 8'h11, 8'h22);
    send_word(16'h0102, 8'h03, 8'hFF, 8'hFF);
    send(8'h51);
    rx_valid = 1'b0;
    check("c3_done", 34'(done), 34'd1);
    check("c3_wc", 34'(word_count), 34'd3);
    check("c3_addr_post", 34'(pm_addr), 34'h103);

    // Reset while in W1
    send_hdr(8'h00, 8'h30, 8'h00, 8'h02);
    send(8'h01);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 34'(busy), 34'd0);
    check("mid_rst_ready", 34'(rx_ready), 34'd1);
    check("mid_rst_pm", {pm_addr, pm_data}, 34'd0);
    check("mid_rst_wc", 34'(word_count), 34'd0);
    check("mid_rst_err", 34'(err_code), 34'd0);
    @(negedge clk);
    rx_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Fresh good frame after reset
    send_hdr(8'h00, 8'h40, 8'h00, 8'h01);
    send_word(16'h0040, 8'h00, 8'h00, 8'h01);
    send(8'hBE);
    rx_valid = 1'b0;
    check("post_rst_done", 34'(done), 34'd1);
    check("post_rst_err", 34'(err_code), 34'd0);

    repeat (3) @(negedge clk);
    check("total_writes", 34'(n_writes), 34'd7);
    check("queue_empty", 34'(exp_q.size()), 34'd0);
    check("total_done", 34'(n_done), 34'd4);
    check("total_ready_low", 34'(n_ready_low), 34'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
